// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch/sequencing front end: FSM encoding,
// jump-select codes, control bundle and the default ack timeout.
package cpu_pkg;

  localparam int DEF_ACK_TIMEOUT = 15;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_DECODE = 3'd2;
  localparam logic [2:0] ST_EXEC   = 3'd3;
  localparam logic [2:0] ST_HALT   = 3'd4;

  localparam logic [1:0] JIJR_NONE = 2'b00;
  localparam logic [1:0] JIJR_JI   = 2'b01;
  localparam logic [1:0] JIJR_JR   = 2'b10;
  localparam logic [1:0] JIJR_RSV  = 2'b11;

  // Control-unit outputs that steer the next-PC choice in EXEC.
  typedef struct packed {
    logic       pc_inc;
    logic       beq;
    logic [1:0] jijr;
  } pc_ctrl_t;

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC selection: Ji > Jr > Beq > PCInc, else halt request.
module pc_next_calc
  import cpu_pkg::*;
(
  input  logic [7:0] pc,
  input  logic [7:0] imm,
  input  logic [7:0] jr_target,
  input  pc_ctrl_t   ctrl,
  input  logic       zero,
  output logic [7:0] next_pc,
  output logic       halt_req
);

  logic [7:0] pc_inc;

  assign pc_inc = pc + 8'd1;

  always_comb begin
    next_pc  = pc;
    halt_req = 1'b0;
    if (ctrl.jijr == JIJR_JI) begin
      next_pc = imm;
    end else if (ctrl.jijr == JIJR_JR) begin
      next_pc = jr_target;
    end else if (ctrl.beq) begin
      // Sign-extending an 8-bit offset into an 8-bit sum is the identity mod 256.
      next_pc = zero ? (pc_inc + imm) : pc_inc;
    end else if (ctrl.pc_inc) begin
      next_pc = pc_inc;
    end else begin
      halt_req = 1'b1;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch/sequencer: IDLE -> FETCH -> DECODE -> EXEC loop with
// ack timeout and sticky Halted/FetchErr status.
module instr_fetch
  import cpu_pkg::*;
#(
  parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        Run,
  output logic        ImemReq,
  output logic [7:0]  ImemAddr,
  input  logic        ImemAck,
  input  logic [15:0] ImemData,
  output logic [3:0]  Oper,
  output logic [7:0]  Imm,
  output logic        InstrValid,
  input  logic        PCInc_Op,
  input  logic        Beq_Op,
  input  logic [1:0]  JiJr_Op,
  input  logic        Zero,
  input  logic [7:0]  JrTarget,
  output logic [7:0]  PC,
  output logic        Halted,
  output logic        FetchErr
);

  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  logic [2:0]       state;
  logic [15:0]      ir;
  logic [CNT_W-1:0] to_cnt;
  pc_ctrl_t         ctrl;
  logic [7:0]       next_pc;
  logic             halt_req;

  assign ctrl       = '{pc_inc: PCInc_Op, beq: Beq_Op, jijr: JiJr_Op};
  assign ImemReq    = (state == ST_FETCH);
  assign InstrValid = (state == ST_DECODE);
  assign ImemAddr   = PC;
  assign Oper       = ir[15:12];
  assign Imm        = ir[7:0];

  pc_next_calc u_pc_next (
    .pc        (PC),
    .imm       (ir[7:0]),
    .jr_target (JrTarget),
    .ctrl      (ctrl),
    .zero      (Zero),
    .next_pc   (next_pc),
    .halt_req  (halt_req)
  );

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state    <= ST_IDLE;
      PC       <= 8'd0;
      ir       <= 16'd0;
      to_cnt   <= '0;
      Halted   <= 1'b0;
      FetchErr <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (Run) state <= ST_FETCH;
        ST_FETCH: begin
          if (ImemAck) begin
            ir     <= ImemData;
            to_cnt <= '0;
            state  <= ST_DECODE;
          end else if (to_cnt == CNT_LAST) begin
            FetchErr <= 1'b1;
            Halted   <= 1'b1;
            state    <= ST_HALT;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        ST_DECODE: state <= ST_EXEC;
        ST_EXEC: begin
          to_cnt <= '0;
          if (halt_req) begin
            Halted <= 1'b1;
            state  <= ST_HALT;
          end else begin
            PC    <= next_pc;
            state <= ST_FETCH;
          end
        end
        // Only reset leaves HALT.
        ST_HALT: state <= ST_HALT;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: sequencing, next-PC selection, timeout, reset.
module tb_instr_fetch;
  import cpu_pkg::*;

  logic        Clk = 1'b0;
  logic        Rst_n, Run, ImemAck, PCInc_Op, Beq_Op, Zero;
  logic [15:0] ImemData;
  logic [1:0]  JiJr_Op;
  logic [7:0]  JrTarget;
  logic        ImemReq, InstrValid, Halted, FetchErr;
  logic [7:0]  ImemAddr, Imm, PC;
  logic [3:0]  Oper;

  int n_chk = 0;
  int n_err = 0;

  instr_fetch #(.ACK_TIMEOUT(15)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Run(Run), .ImemReq(ImemReq), .ImemAddr(ImemAddr),
    .ImemAck(ImemAck), .ImemData(ImemData), .Oper(Oper), .Imm(Imm),
    .InstrValid(InstrValid), .PCInc_Op(PCInc_Op), .Beq_Op(Beq_Op),
    .JiJr_Op(JiJr_Op), .Zero(Zero), .JrTarget(JrTarget), .PC(PC),
    .Halted(Halted), .FetchErr(FetchErr)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic clr_ctrl();
    PCInc_Op = 1'b0; Beq_Op = 1'b0; JiJr_Op = JIJR_NONE; Zero = 1'b0; JrTarget = 8'h00;
  endtask

  task automatic do_reset();
    Rst_n = 1'b0; Run = 1'b0; ImemAck = 1'b0; ImemData = 16'h0000; clr_ctrl();
    step(); step();
    Rst_n = 1'b1;
  endtask

  // Called in FETCH; returns after the EXEC edge (FETCH or HALT).
  task automatic do_instr(input logic [15:0] data, input logic pcinc, input logic beq,
                          input logic [1:0] jijr, input logic zero, input logic [7:0] jr);
    ImemAck = 1'b1; ImemData = data;
    step();
    ImemAck = 1'b0; ImemData = 16'hDEAD;
    PCInc_Op = pcinc; Beq_Op = beq; JiJr_Op = jijr; Zero = zero; JrTarget = jr;
    step();
    step();
    clr_ctrl();
  endtask

  initial begin
    do_reset();
    chk("rst_pc", PC, 8'h00);
    chk("rst_req", ImemReq, 1'b0);
    chk("rst_valid", InstrValid, 1'b0);
    chk("rst_halt", Halted, 1'b0);
    chk("rst_ferr", FetchErr, 1'b0);
    chk("rst_oper_imm", {Oper, Imm}, 12'h000);

    step();
    chk("idle_hold_req", ImemReq, 1'b0);
    Run = 1'b1;
    step();
    chk("fetch_req", ImemReq, 1'b1);
    chk("fetch_addr", ImemAddr, 8'h00);
    Run = 1'b0;
    ImemAck = 1'b1; ImemData = 16'h1234;
    step();
    ImemAck = 1'b0; ImemData = 16'hFFFF;
    chk("dec_valid", InstrValid, 1'b1);
    chk("dec_req", ImemReq, 1'b0);
    chk("dec_oper", Oper, 4'h1);
    chk("dec_imm", Imm, 8'h34);
    PCInc_Op = 1'b1;
    step();
    chk("exec_valid", InstrValid, 1'b0);
    step();
    clr_ctrl();
    chk("inc_pc", PC, 8'h01);
    chk("refetch_req", ImemReq, 1'b1);
    chk("hold_oper_imm", {Oper, Imm}, 12'h134);

    do_instr(16'h0010, 1'b0, 1'b0, JIJR_JI, 1'b0, 8'h00);
    chk("ji_pc10", PC, 8'h10);
    do_instr(16'h00FE, 1'b0, 1'b1, JIJR_NONE, 1'b1, 8'h00);
    chk("beq_taken", PC, 8'h0F);
    do_instr(16'h0010, 1'b0, 1'b0, JIJR_JI, 1'b0, 8'h00);
    do_instr(16'h00FE, 1'b0, 1'b1, JIJR_NONE, 1'b0, 8'h00);
    chk("beq_not_taken", PC, 8'h11);
    do_instr(16'h0080, 1'b1, 1'b1, JIJR_JI, 1'b1, 8'h55);
    chk("ji_wins", PC, 8'h80);
    do_instr(16'h0007, 1'b1, 1'b1, JIJR_JR, 1'b1, 8'h3C);
    chk("jr", PC, 8'h3C);
    do_instr(16'h0040, 1'b1, 1'b0, JIJR_RSV, 1'b0, 8'h99);
    chk("rsv_as_none", PC, 8'h3D);
    do_instr(16'h00FF, 1'b0, 1'b0, JIJR_JI, 1'b0, 8'h00);
    do_instr(16'h0000, 1'b1, 1'b0, JIJR_NONE, 1'b0, 8'h00);
    chk("wrap_pc", PC, 8'h00);
    chk("wrap_flags", {Halted, FetchErr}, 2'b00);
    do_instr(16'h0000, 1'b0, 1'b0, JIJR_NONE, 1'b0, 8'h00);
    chk("halt_flag", Halted, 1'b1);
    chk("halt_pc", PC, 8'h00);
    chk("halt_req", ImemReq, 1'b0);
    for (int i = 0; i < 4; i++) begin
      Run = ~Run;
      ImemAck = 1'b1;
      step();
    end
    ImemAck = 1'b0;
    chk("halt_sticky", {Halted, ImemReq, InstrValid, FetchErr}, 4'b1000);

    // Ack withheld for 15 FETCH cycles.
    do_reset();
    Run = 1'b1;
    step();
    Run = 1'b0;
    for (int i = 0; i < 14; i++) step();
    chk("to_cyc15_req", ImemReq, 1'b1);
    chk("to_cyc15_ferr", FetchErr, 1'b0);
    step();
    chk("to_ferr", FetchErr, 1'b1);
    chk("to_halt", Halted, 1'b1);
    chk("to_req_off", ImemReq, 1'b0);

    // Ack arriving on the 15th cycle is in time.
    do_reset();
    Run = 1'b1;
    step();
    Run = 1'b0;
    for (int i = 0; i < 14; i++) step();
    ImemAck = 1'b1; ImemData = 16'hA5C3;
    step();
    ImemAck = 1'b0;
    chk("late_ack_valid", InstrValid, 1'b1);
    chk("late_ack_flags", {Halted, FetchErr}, 2'b00);
    chk("late_ack_ir", {Oper, Imm}, 12'hAC3);

    // Reset coinciding with an ack in FETCH.
    do_reset();
    Run = 1'b1;
    step();
    chk("pre_rst_req", ImemReq, 1'b1);
    ImemAck = 1'b1; ImemData = 16'hABCD; Rst_n = 1'b0;
    step();
    ImemAck = 1'b0; Rst_n = 1'b1; Run = 1'b0;
    chk("rst_ack_req", ImemReq, 1'b0);
    chk("rst_ack_ir", {Oper, Imm}, 12'h000);
    chk("rst_ack_valid", InstrValid, 1'b0);
    step();
    chk("rst_ack_idle", ImemReq, 1'b0);
    Run = 1'b1;
    step();
    chk("rst_ack_refetch", ImemReq, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
